// File: rtl/if_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// if_prefetch_pkg
//   Shared constants and helpers for the instruction-fetch prefetch unit:
//   chip-enable / reset-active levels, zero word, PC increment, perf counter
//   type and a small population-count helper for the in-flight tracker.
// -----------------------------------------------------------------------------
package if_prefetch_pkg;

  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam int unsigned PC_INC       = 4;

  // Upper bound on ROM read latency; sizes the in-flight popcount.
  localparam int unsigned MAX_ROM_LAT  = 4;

  typedef logic [31:0] perf_cnt_t;

  // Number of set bits in an in-flight valid vector.
  function automatic int unsigned count_ones(input logic [MAX_ROM_LAT-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(MAX_ROM_LAT); i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// if_fifo
//   Synchronous FIFO holding fetched {instruction, pc} pairs for if_prefetch.
//   The head entry is registered so the consumer sees a flop output; the head
//   reads as all-zero whenever the FIFO is empty.
//
//   Ports
//     clk, rst    clock, synchronous active-high reset
//     clear       drop every entry (redirect flush); wins over push/pop
//     push        write push_data at the tail (ignored when full and not popping)
//     push_data   WIDTH-bit entry
//     pop         remove the head entry (ignored when empty)
//     count_o     number of stored entries, 0..DEPTH
//     head_o      registered head entry, zero when empty
//
//   DEPTH must be a power of two (pointers wrap by overflow) and at least 2.
// -----------------------------------------------------------------------------
module if_fifo
  import if_prefetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [WIDTH-1:0]             head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      // Next head: nothing left, the word being pushed into an (effectively)
      // empty FIFO, or the stored entry at the new read pointer.
      if (count_d == '0) begin
        head_d = '0;
      end else if (do_push && ((count_q - CNT_W'(do_pop)) == '0)) begin
        head_d = push_data;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // NOTE: storage has no reset; count_q gates every read, so stale contents
  // are never observed and the array maps onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch
//   Instruction-fetch unit with a prefetch buffer. Issues sequential word
//   fetches to an instruction ROM of fixed read latency ROM_LAT, tracks them in
//   a ROM_LAT-stage in-flight shift, buffers returned words in if_fifo and
//   presents the head to the IF/ID register. A redirect flushes buffered and
//   in-flight fetches and restarts at redirect_pc_i.
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     rom_ce_o          ROM read request this cycle
//     rom_addr_o        ROM read address (0 when no request)
//     rom_data_i        ROM word, valid ROM_LAT cycles after its request
//     stall_i           consumer cannot accept; head word is held
//     redirect_i        flush and restart fetch at redirect_pc_i
//     redirect_pc_i     new fetch address
//     inst_valid_o      inst_o/pc_o hold a valid buffered word
//     inst_o, pc_o      head instruction and its address (0 when empty)
//     perf_fetch_o      issued-fetch counter
//     perf_kill_o       discarded-fetch counter
//
//   Configuration macro IF_PERF_EN: when defined, perf_fetch_o / perf_kill_o
//   are live 32-bit wrapping counters; otherwise they are tied to zero.
//
//   Credit rule: a fetch issues only when buffered + in-flight < DEPTH, so a
//   returning word always has a FIFO slot. Full rate needs DEPTH >= ROM_LAT+2.
// -----------------------------------------------------------------------------
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ROM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [31:0]       perf_fetch_o,
  output logic [31:0]       perf_kill_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  // At least one stage is declared so ROM_LAT=0 still elaborates; it stays 0.
  localparam int unsigned STG_N = (ROM_LAT == 0) ? 1 : ROM_LAT;

  logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic [STG_N-1:0]         stg_vld_q, stg_vld_d;
  logic [ADDR_W-1:0]        stg_pc_q [STG_N];
  logic [ADDR_W-1:0]        stg_pc_d [STG_N];

  logic [CNT_W-1:0]         fifo_count;
  logic [DATA_W+ADDR_W-1:0] fifo_head;
  logic [2:0]               inflight;
  logic                     issue;
  logic                     push;
  logic                     pop;
  logic [ADDR_W-1:0]        push_pc;

  // In-flight count comes from the registered stage valids only.
  assign inflight = 3'(count_ones(MAX_ROM_LAT'(stg_vld_q)));

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    issue = (rst != RST_ENABLE) && !redirect_i &&
            ((32'(fifo_count) + 32'(inflight)) < DEPTH);

    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
    end

    // In-flight shift; a redirect leaves every stage invalid.
    stg_vld_d = '0;
    for (int i = 0; i < int'(STG_N); i++) begin
      stg_pc_d[i] = '0;
    end
    if ((ROM_LAT != 0) && !redirect_i) begin
      stg_vld_d[0] = issue;
      stg_pc_d[0]  = fetch_pc_q;
      for (int i = 1; i < int'(STG_N); i++) begin
        stg_vld_d[i] = stg_vld_q[i-1];
        stg_pc_d[i]  = stg_pc_q[i-1];
      end
    end

    // Returning word: same cycle for a combinational ROM, else from the
    // oldest stage. Data arriving during a redirect is discarded.
    if (ROM_LAT == 0) begin
      push    = issue;
      push_pc = fetch_pc_q;
    end else begin
      push    = stg_vld_q[STG_N-1] && !redirect_i;
      push_pc = stg_pc_q[STG_N-1];
    end

    pop = inst_valid_o && !stall_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      fetch_pc_q <= RESET_PC;
      stg_vld_q  <= '0;
      for (int i = 0; i < int'(STG_N); i++) begin
        stg_pc_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      stg_vld_q  <= stg_vld_d;
      for (int i = 0; i < int'(STG_N); i++) begin
        stg_pc_q[i] <= stg_pc_d[i];
      end
    end
  end

  if_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_i),
    .push      (push),
    .push_data ({rom_data_i, push_pc}),
    .pop       (pop),
    .count_o   (fifo_count),
    .head_o    (fifo_head)
  );

  // Outputs are forced to zero while reset is asserted, before the
  // synchronous reset has taken effect on the registers.
  assign rom_ce_o     = issue ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr_o   = issue ? fetch_pc_q : '0;
  assign inst_valid_o = (rst != RST_ENABLE) && (fifo_count != '0);
  assign inst_o       = (rst == RST_ENABLE) ? DATA_W'(ZERO_WORD) : fifo_head[DATA_W+ADDR_W-1:ADDR_W];
  assign pc_o         = (rst == RST_ENABLE) ? ADDR_W'(ZERO_WORD) : fifo_head[ADDR_W-1:0];

`ifdef IF_PERF_EN
  perf_cnt_t perf_fetch_q, perf_fetch_d;
  perf_cnt_t perf_kill_q, perf_kill_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + perf_cnt_t'(issue);
    perf_kill_d  = perf_kill_q;
    // Everything discarded by a redirect: buffered words plus live stages.
    if (redirect_i) begin
      perf_kill_d = perf_kill_q + perf_cnt_t'(fifo_count) + perf_cnt_t'(inflight);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      perf_fetch_q <= '0;
      perf_kill_q  <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_kill_q  <= perf_kill_d;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_kill_o  = perf_kill_q;
`else
  assign perf_fetch_o = '0;
  assign perf_kill_o  = '0;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch
//   Four if_prefetch instances (ROM_LAT/DEPTH = 1/4, 0/4, 3/8, 2/8) share one
//   stimulus stream. Each has its own ROM model and a queue-based reference
//   model checked every cycle; directed phases add literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_prefetch;

  localparam int NCFG = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  left;
  } flight_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int n_vec = 0;
  int n_err = 0;

  logic        ce_m    [NCFG];
  logic        valid_m [NCFG];
  logic [31:0] addr_m  [NCFG];
  logic [31:0] pc_m    [NCFG];
  logic [31:0] inst_m  [NCFG];
  logic [31:0] kill_m  [NCFG];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int          LAT = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 2;
    localparam int          DEP = (g < 2) ? 4 : 8;
    localparam int          LI  = (LAT == 0) ? 0 : LAT - 1;
    localparam logic [31:0] RPC = (g == 3) ? 32'h0000_1000 : 32'h0;

    logic        ce, valid;
    logic [31:0] addr, rdata, inst, pc, pf, pk;
    logic        rv_q [4] = '{default: 1'b0};
    logic [31:0] ra_q [4] = '{default: 32'h0};
    logic [31:0] junk_q = 32'h0;

    if_prefetch #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .DEPTH    (DEP),
      .ROM_LAT  (LAT),
      .RESET_PC (RPC)
    ) dut (
      .clk           (clk),
      .rst           (rst),
      .rom_ce_o      (ce),
      .rom_addr_o    (addr),
      .rom_data_i    (rdata),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .inst_valid_o  (valid),
      .inst_o        (inst),
      .pc_o          (pc),
      .perf_fetch_o  (pf),
      .perf_kill_o   (pk)
    );

    // ROM: answers each request LAT cycles later, garbage when none is due.
    always @(posedge clk) begin
      rv_q[0] <= ce;
      ra_q[0] <= addr;
      junk_q  <= $urandom;
      for (int i = 1; i < 4; i++) begin
        rv_q[i] <= rv_q[i-1];
        ra_q[i] <= ra_q[i-1];
      end
    end
    assign rdata = (LAT == 0) ? rom_word(addr) :
                   (rv_q[LI] ? rom_word(ra_q[LI]) : junk_q);

    assign ce_m[g]    = ce;
    assign valid_m[g] = valid;
    assign addr_m[g]  = addr;
    assign pc_m[g]    = pc;
    assign inst_m[g]  = inst;
    assign kill_m[g]  = pk;

    // Reference model: buffered pcs and outstanding requests as queues.
    initial begin
      logic [31:0] fpc, e_addr, e_pc, e_inst, e_fetch, e_kill;
      logic        e_ce, e_valid;
      logic [31:0] bq [$];
      flight_t     fl [$];
      flight_t     nf [$];
      flight_t     f;
      fpc = RPC;
      e_fetch = 0;
      e_kill = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          e_ce = 0; e_addr = 0; e_valid = 0; e_pc = 0; e_inst = 0;
        end else begin
          e_valid = (bq.size() != 0);
          e_pc    = e_valid ? bq[0] : 32'h0;
          e_inst  = e_valid ? rom_word(bq[0]) : 32'h0;
          e_ce    = !redirect && ((bq.size() + fl.size()) < DEP);
          e_addr  = e_ce ? fpc : 32'h0;
        end
        check($sformatf("cfg%0d rom_ce", g), 32'(ce), 32'(e_ce));
        check($sformatf("cfg%0d rom_addr", g), addr, e_addr);
        check($sformatf("cfg%0d inst_valid", g), 32'(valid), 32'(e_valid));
        check($sformatf("cfg%0d pc", g), pc, e_pc);
        check($sformatf("cfg%0d inst", g), inst, e_inst);
        if (!rst) begin
`ifdef IF_PERF_EN
          check($sformatf("cfg%0d perf_fetch", g), pf, e_fetch);
          check($sformatf("cfg%0d perf_kill", g), pk, e_kill);
`else
          check($sformatf("cfg%0d perf_fetch", g), pf, 32'h0);
          check($sformatf("cfg%0d perf_kill", g), pk, 32'h0);
`endif
        end
        // Advance to the state after the coming posedge.
        if (rst) begin
          bq.delete(); fl.delete();
          fpc = RPC; e_fetch = 0; e_kill = 0;
        end else if (redirect) begin
          e_kill = e_kill + 32'(bq.size() + fl.size());
          bq.delete(); fl.delete();
          fpc = redirect_pc;
        end else begin
          if (e_valid && !stall) void'(bq.pop_front());
          nf.delete();
          for (int i = 0; i < fl.size(); i++) begin
            f = fl[i];
            f.left = f.left - 4'd1;
            if (f.left == 0) bq.push_back(f.pc);
            else             nf.push_back(f);
          end
          fl = nf;
          if (e_ce) begin
            if (LAT == 0) begin
              bq.push_back(fpc);
            end else begin
              f.pc = fpc;
              f.left = 4'(LAT);
              fl.push_back(f);
            end
            fpc = fpc + 32'd4;
            e_fetch = e_fetch + 32'd1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_iss;

    // 1: reset, then free-running fetch.
    repeat (4) tick();
    @(negedge clk);
    check("rst rom_ce", 32'(ce_m[0]), 32'h0);
    check("rst rom_addr", addr_m[0], 32'h0);
    check("rst inst_valid", 32'(valid_m[0]), 32'h0);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("t1 c0 addr", addr_m[0], 32'h0);
    check("t1 c0 ce", 32'(ce_m[0]), 32'h1);
    tick(); @(negedge clk);
    check("t1 c1 addr", addr_m[0], 32'h4);
    check("t1 c1 valid", 32'(valid_m[0]), 32'h0);
    tick(); @(negedge clk);
    check("t1 c2 addr", addr_m[0], 32'h8);
    check("t1 c2 valid", 32'(valid_m[0]), 32'h1);
    check("t1 c2 pc", pc_m[0], 32'h0);
    check("t1 c2 inst", inst_m[0], rom_word(32'h0));
    for (int i = 0; i < 10; i++) begin
      tick(); @(negedge clk);
      check("t1 lat3 full rate", 32'(ce_m[2]), 32'h1);
      check("t1 lat1 full rate", 32'(ce_m[0]), 32'h1);
    end

    // 2: stall from reset release fills the buffer, then drain in order.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; stall = 1'b1;
    n_iss = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ce_m[0]) n_iss++;
      tick();
    end
    check("t2 issues", 32'(n_iss), 32'd4);
    @(negedge clk);
    check("t2 full ce", 32'(ce_m[0]), 32'h0);
    check("t2 head pc", pc_m[0], 32'h0);
    tick(); stall = 1'b0;
    @(negedge clk);
    check("t2 r0 pc", pc_m[0], 32'h0);
    check("t2 r0 ce", 32'(ce_m[0]), 32'h0);
    tick(); @(negedge clk);
    check("t2 r1 pc", pc_m[0], 32'h4);
    check("t2 r1 addr", addr_m[0], 32'h10);
    tick(); @(negedge clk);
    check("t2 r2 pc", pc_m[0], 32'h8);
    tick(); @(negedge clk);
    check("t2 r3 pc", pc_m[0], 32'hC);
    tick(); @(negedge clk);
    check("t2 r4 pc", pc_m[0], 32'h10);

    // 3: redirect with 3 buffered + 2 in flight on the LAT=2 instance.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; stall = 1'b1;
    repeat (5) tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick(); redirect = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("t3 cfg%0d valid", g), 32'(valid_m[g]), 32'h0);
      check($sformatf("t3 cfg%0d addr", g), addr_m[g], 32'h100);
    end
`ifdef IF_PERF_EN
    check("t3 perf_kill", kill_m[3], 32'd5);
`endif

    // 6: redirect while stalled with a full buffer.
    repeat (12) tick();
    @(negedge clk);
    check("t6 full ce", 32'(ce_m[0]), 32'h0);
    tick(); redirect = 1'b1; redirect_pc = 32'h200;
    tick(); redirect = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("t6 cfg%0d valid", g), 32'(valid_m[g]), 32'h0);
      check($sformatf("t6 cfg%0d addr", g), addr_m[g], 32'h200);
    end

    // 5: address wrap, then a reset pulse mid-stream.
    tick(); stall = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick(); redirect = 1'b0;
    @(negedge clk);
    check("t5 addr0", addr_m[0], 32'hFFFF_FFF8);
    tick(); @(negedge clk);
    check("t5 addr1", addr_m[0], 32'hFFFF_FFFC);
    tick(); @(negedge clk);
    check("t5 wrap", addr_m[0], 32'h0);
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("t5 cfg%0d rst ce", g), 32'(ce_m[g]), 32'h0);
      check($sformatf("t5 cfg%0d rst valid", g), 32'(valid_m[g]), 32'h0);
      check($sformatf("t5 cfg%0d rst pc", g), pc_m[g], 32'h0);
    end
    tick(); rst = 1'b0;
    @(negedge clk);
    check("t5 restart cfg0", addr_m[0], 32'h0);
    check("t5 restart cfg3", addr_m[3], 32'h1000);
    check("t5 restart valid", 32'(valid_m[0]), 32'h0);

    // 4: randomized traffic against the models.
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst      = ($urandom_range(0, 299) == 0);
      redirect = ($urandom_range(0, 24) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                : ($urandom & 32'hFFFF_FFFC);
      if ((i / 500) % 2 == 0) stall = ($urandom_range(0, 99) < 30);
      else                    stall = ($urandom_range(0, 99) < 80);
    end
    tick(); rst = 1'b0; redirect = 1'b0; stall = 1'b0;
    repeat (3) tick();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
